// File: rtl/spi_master_byte.sv
// SPI mode-0 byte master: MSB first, valid/ready byte stream in,
// tx_last closes the message and releases SSEL.
module spi_master_byte #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SSEL
);

    typedef enum logic [2:0] {
        IDLE, SETUP, LOW, HIGH, NEXT, HOLD, GAP
    } state_e;

    localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
    localparam logic [15:0] IDLE_END  = 16'(CS_IDLE - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        last_q, last_d;
    logic        rx_valid_q, rx_valid_d;
    logic        busy_q, busy_d;
    logic        tx_ready_q, tx_ready_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        ssel_q, ssel_d;
    logic        xfer;

    assign xfer = tx_valid & tx_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        last_d     = last_q;
        rx_valid_d = 1'b0;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ssel_d     = ssel_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (xfer) begin
                    tx_sh_d = tx_data;
                    last_d  = tx_last;
                    mosi_d  = tx_data[7];
                    ssel_d  = 1'b0;
                    bit_d   = 3'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_END) begin
                    cnt_d   = 16'd0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (cnt_q == DIV_END) begin
                    cnt_d   = 16'd0;
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], MISO};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (cnt_q == DIV_END) begin
                    cnt_d = 16'd0;
                    sck_d = 1'b0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        state_d    = last_q ? HOLD : NEXT;
                    end else begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        mosi_d  = tx_sh_q[6];
                        state_d = LOW;
                    end
                end
            end
            NEXT: begin
                cnt_d = 16'd0;
                if (xfer) begin
                    tx_sh_d = tx_data;
                    last_d  = tx_last;
                    mosi_d  = tx_data[7];
                    state_d = LOW;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_END) begin
                    cnt_d   = 16'd0;
                    ssel_d  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == IDLE_END) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        // First NEXT cycle carries rx_valid, so acceptance waits one cycle.
        tx_ready_d = (state_d == IDLE)
                   || (state_d == NEXT && state_q == NEXT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            bit_q      <= 3'd0;
            tx_sh_q    <= 8'h00;
            rx_sh_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            last_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ssel_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ssel_q     <= ssel_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign SCK      = sck_q;
    assign MOSI     = mosi_q;
    assign SSEL     = ssel_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte: default build plus a CLK_DIV=7
// build, loopback and a mode-0 slave model on MISO.
module tb_spi_master_byte;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] tx_data;
    logic       tx_last, tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy, sck, mosi, miso, ssel;

    logic [7:0] tx_data7;
    logic       tx_last7, tx_valid7, tx_ready7;
    logic [7:0] rx_data7;
    logic       rx_valid7, busy7, sck7, mosi7, ssel7;

    int pass_n = 0;
    int total_n = 0;

    logic       loop_en;
    logic [7:0] resp [4];
    logic [1:0] sl_byte;
    logic [2:0] sl_bit;

    assign miso = loop_en ? mosi : resp[sl_byte][~sl_bit];

    spi_master_byte u_dut (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .SCK(sck), .MOSI(mosi), .MISO(miso), .SSEL(ssel)
    );

    spi_master_byte #(.CLK_DIV(7)) u_dut7 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data7), .tx_last(tx_last7),
        .tx_valid(tx_valid7), .tx_ready(tx_ready7),
        .rx_data(rx_data7), .rx_valid(rx_valid7), .busy(busy7),
        .SCK(sck7), .MOSI(mosi7), .MISO(mosi7), .SSEL(ssel7)
    );

    // Bus monitor for the default build
    logic [7:0] rxq [$];
    logic [7:0] txq [$];
    logic [7:0] mshift;
    int mbits, sck_rises, ssel_falls, ssel_rises, ssel_low;
    int high_run, last_high;
    logic sck_p = 1'b0;
    logic ssel_p = 1'b1;

    always @(negedge clk) begin
        if (sck && !sck_p) begin
            sck_rises++;
            mshift = {mshift[6:0], mosi};
            mbits++;
            if (mbits == 8) begin
                txq.push_back(mshift);
                mbits = 0;
            end
            if (sl_bit == 3'd7) sl_byte = sl_byte + 2'd1;
            sl_bit = sl_bit + 3'd1;
        end
        if (!ssel && ssel_p) begin
            ssel_falls++;
            last_high = high_run;
        end
        if (ssel && !ssel_p) ssel_rises++;
        if (ssel) high_run++;
        else begin
            high_run = 0;
            ssel_low++;
        end
        if (rx_valid) rxq.push_back(rx_data);
        sck_p = sck;
        ssel_p = ssel;
    end

    // Phase-length monitor for the CLK_DIV=7 build
    logic [7:0] rx7q [$];
    int run7, hi_min, hi_max, lo_min, lo_max, hi_n, lo_n;
    logic lo_ok = 1'b0;
    logic sck7_p = 1'b0;

    always @(negedge clk) begin
        if (sck7 != sck7_p) begin
            if (sck7_p) begin
                hi_n++;
                if (run7 < hi_min) hi_min = run7;
                if (run7 > hi_max) hi_max = run7;
                lo_ok = 1'b1;
            end else if (lo_ok) begin
                lo_n++;
                if (run7 < lo_min) lo_min = run7;
                if (run7 > lo_max) lo_max = run7;
            end
            run7 = 1;
        end else begin
            run7++;
        end
        if (ssel7) lo_ok = 1'b0;
        if (rx_valid7) rx7q.push_back(rx_data7);
        sck7_p = sck7;
    end

    task automatic clear_mon();
        @(posedge clk);
        #1;
        rxq.delete();
        txq.delete();
        mbits = 0;
        mshift = 8'h00;
        sck_rises = 0;
        ssel_falls = 0;
        ssel_rises = 0;
        ssel_low = 0;
        sl_byte = 2'd0;
        sl_bit = 3'd0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int k = 0;
        tx_data = d;
        tx_last = l;
        tx_valid = 1'b1;
        while (!tx_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        total_n++;
        if (k >= 3000) $display("FAIL send_%h: tx_ready never 1", d);
        else pass_n++;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while ((rxq.size() < n || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        total_n++;
        if (k >= 3000)
            $display("FAIL wait_done: rx=%0d busy=%b want rx=%0d idle",
                     rxq.size(), busy, n);
        else pass_n++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_n++;
        if ({sck, ssel, mosi, rx_valid, busy, tx_ready} !== 6'b010000)
            $display("FAIL reset_ctl: sck,ssel,mosi,rxv,busy,rdy=%b want 010000",
                     {sck, ssel, mosi, rx_valid, busy, tx_ready});
        else pass_n++;
        total_n++;
        if (rx_data !== 8'h00)
            $display("FAIL reset_rx_data: got %h want 00", rx_data);
        else pass_n++;
        rst_n = 1'b1;
        @(negedge clk);
        total_n++;
        if (tx_ready !== 1'b1)
            $display("FAIL reset_release_ready: got %b want 1", tx_ready);
        else pass_n++;
    endtask

    task automatic test_loopback();
        loop_en = 1'b1;
        clear_mon();
        send(8'hA5, 1'b1);
        wait_done(1);
        total_n++;
        if (rxq.size() != 1 || rxq[0] !== 8'hA5)
            $display("FAIL lb_rx: n=%0d got %h want 1 x a5", rxq.size(), rxq[0]);
        else pass_n++;
        total_n++;
        if (sck_rises != 8)
            $display("FAIL lb_sck_rises: got %0d want 8", sck_rises);
        else pass_n++;
        total_n++;
        if (ssel_low != 68)
            $display("FAIL lb_ssel_low: got %0d want 68", ssel_low);
        else pass_n++;
        total_n++;
        if (ssel_falls != 1 || ssel_rises != 1 || ssel !== 1'b1)
            $display("FAIL lb_ssel_edges: fall=%0d rise=%0d want 1/1",
                     ssel_falls, ssel_rises);
        else pass_n++;
    endtask

    task automatic test_back_to_back();
        loop_en = 1'b1;
        clear_mon();
        send(8'h3E, 1'b1);
        send(8'h7D, 1'b1);
        wait_done(2);
        total_n++;
        if (rxq.size() != 2 || rxq[0] !== 8'h3E || rxq[1] !== 8'h7D)
            $display("FAIL b2b_rx: n=%0d got %h %h want 3e 7d",
                     rxq.size(), rxq[0], rxq[1]);
        else pass_n++;
        total_n++;
        if (ssel_falls != 2 || last_high < 2)
            $display("FAIL b2b_gap: falls=%0d gap=%0d want 2 and >=2",
                     ssel_falls, last_high);
        else pass_n++;
    endtask

    task automatic test_three_byte();
        loop_en = 1'b0;
        clear_mon();
        send(8'h01, 1'b0);
        send(8'h80, 1'b0);
        send(8'hFF, 1'b1);
        wait_done(3);
        total_n++;
        if (rxq.size() != 3 || rxq[0] !== 8'h00 || rxq[1] !== 8'h01
            || rxq[2] !== 8'h02)
            $display("FAIL tri_rx: n=%0d got %h %h %h want 00 01 02",
                     rxq.size(), rxq[0], rxq[1], rxq[2]);
        else pass_n++;
        total_n++;
        if (txq.size() != 3 || txq[0] !== 8'h01 || txq[1] !== 8'h80
            || txq[2] !== 8'hFF)
            $display("FAIL tri_mosi: n=%0d got %h %h %h want 01 80 ff",
                     txq.size(), txq[0], txq[1], txq[2]);
        else pass_n++;
        total_n++;
        if (sck_rises != 24 || ssel_falls != 1 || ssel_rises != 1)
            $display("FAIL tri_frame: sck=%0d fall=%0d rise=%0d want 24/1/1",
                     sck_rises, ssel_falls, ssel_rises);
        else pass_n++;
    endtask

    task automatic test_stall();
        int k = 0;
        logic bad = 1'b0;
        logic mref;
        loop_en = 1'b1;
        clear_mon();
        send(8'h12, 1'b0);
        while (rxq.size() < 1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        mref = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (sck !== 1'b0 || ssel !== 1'b0 || mosi !== mref) bad = 1'b1;
        end
        total_n++;
        if (bad || k >= 3000)
            $display("FAIL stall_bus: bad=%b sck=%b ssel=%b mosi=%b want 0 0 0",
                     bad, sck, ssel, mosi);
        else pass_n++;
        send(8'h34, 1'b1);
        wait_done(2);
        total_n++;
        if (rxq.size() != 2 || rxq[0] !== 8'h12 || rxq[1] !== 8'h34
            || ssel_falls != 1)
            $display("FAIL stall_resume: n=%0d got %h %h falls=%0d want 12 34 1",
                     rxq.size(), rxq[0], rxq[1], ssel_falls);
        else pass_n++;
    endtask

    task automatic test_ignore_busy();
        int k = 0;
        logic bad = 1'b0;
        loop_en = 1'b1;
        clear_mon();
        send(8'h81, 1'b0);
        repeat (10) @(negedge clk);
        tx_data = 8'h3C;
        tx_last = 1'b1;
        tx_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx_ready !== 1'b0) bad = 1'b1;
        end
        tx_valid = 1'b0;
        total_n++;
        if (bad)
            $display("FAIL ign_ready: tx_ready seen 1 mid-byte want 0");
        else pass_n++;
        while (rxq.size() < 1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        send(8'h3C, 1'b1);
        wait_done(2);
        total_n++;
        if (rxq.size() != 2 || rxq[0] !== 8'h81 || rxq[1] !== 8'h3C)
            $display("FAIL ign_rx: n=%0d got %h %h want 81 3c",
                     rxq.size(), rxq[0], rxq[1]);
        else pass_n++;
        total_n++;
        if (txq.size() != 2 || txq[0] !== 8'h81 || txq[1] !== 8'h3C)
            $display("FAIL ign_mosi: n=%0d got %h %h want 81 3c",
                     txq.size(), txq[0], txq[1]);
        else pass_n++;
    endtask

    task automatic test_reset_mid();
        int k = 0;
        loop_en = 1'b1;
        clear_mon();
        send(8'h5A, 1'b1);
        while (sck_rises < 3 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total_n++;
        if (ssel !== 1'b1 || sck !== 1'b0 || busy !== 1'b0 || k >= 3000)
            $display("FAIL rstmid_bus: ssel=%b sck=%b busy=%b want 1 0 0",
                     ssel, sck, busy);
        else pass_n++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_n++;
        if (rxq.size() != 0 || tx_ready !== 1'b1)
            $display("FAIL rstmid_after: rx_n=%0d rdy=%b want 0 1",
                     rxq.size(), tx_ready);
        else pass_n++;
        clear_mon();
        send(8'hC3, 1'b1);
        wait_done(1);
        total_n++;
        if (rxq.size() != 1 || rxq[0] !== 8'hC3 || txq[0] !== 8'hC3)
            $display("FAIL rstmid_fresh: n=%0d got %h mosi %h want c3",
                     rxq.size(), rxq[0], txq[0]);
        else pass_n++;
    endtask

    task automatic test_div7();
        int k = 0;
        hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
        hi_n = 0; lo_n = 0;
        rx7q.delete();
        tx_data7 = 8'h96;
        tx_last7 = 1'b1;
        tx_valid7 = 1'b1;
        while (!tx_ready7 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        tx_valid7 = 1'b0;
        while ((rx7q.size() < 1 || busy7) && k < 6000) begin
            @(negedge clk);
            k++;
        end
        total_n++;
        if (rx7q.size() != 1 || rx7q[0] !== 8'h96 || k >= 6000)
            $display("FAIL div7_rx: n=%0d got %h want 96", rx7q.size(), rx7q[0]);
        else pass_n++;
        total_n++;
        if (hi_n != 8 || hi_min != 7 || hi_max != 7)
            $display("FAIL div7_high: n=%0d min=%0d max=%0d want 8/7/7",
                     hi_n, hi_min, hi_max);
        else pass_n++;
        total_n++;
        if (lo_n != 7 || lo_min != 7 || lo_max != 7)
            $display("FAIL div7_low: n=%0d min=%0d max=%0d want 7/7/7",
                     lo_n, lo_min, lo_max);
        else pass_n++;
    endtask

    initial begin
        resp[0] = 8'h00; resp[1] = 8'h01; resp[2] = 8'h02; resp[3] = 8'h00;
        loop_en = 1'b1;
        sl_byte = 2'd0; sl_bit = 3'd0;
        mshift = 8'h00; mbits = 0;
        sck_rises = 0; ssel_falls = 0; ssel_rises = 0; ssel_low = 0;
        high_run = 0; last_high = 0; run7 = 0;
        tx_data = 8'h00; tx_last = 1'b0; tx_valid = 1'b0;
        tx_data7 = 8'h00; tx_last7 = 1'b0; tx_valid7 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_loopback();
        test_back_to_back();
        test_three_byte();
        test_stall();
        test_ignore_busy();
        test_reset_mid();
        test_div7();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
